rx_uart_cfg: RTL and testbench

//  Runtime-configurable UART receiver; successor of the fixed 8N1 receiver on the SoC peripheral bus.

---
 rtl/rx_uart_cfg_if.sv | 35 +++
 rtl/rx_uart_cfg.sv | 254 +++++++++++++++++++++++++
 tb/tb_rx_uart_cfg.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_uart_cfg_if.sv
// Bus-side signal bundle for rx_uart_cfg: serial line, runtime configuration, FIFO read port and status.
// The slave modport is the receiver's view; the master modport is the bus/line driver's view.
interface rx_uart_cfg_if #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
);
    logic                          rx_in;
    logic [DIV_WIDTH-1:0]          cfg_divisor;
    logic [1:0]                    cfg_data_bits;
    logic                          cfg_stop2;
    logic                          cfg_parity_en;
    logic                          cfg_parity_odd;
    logic                          data_rd;
    logic                          err_clr;
    logic [31:0]                   data;
    logic                          rx_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          framing_err;
    logic                          parity_err;
    logic                          overrun_err;
    logic                          break_det;
    logic [2:0]                    dbg_state;

    modport slave (
        input  rx_in, cfg_divisor, cfg_data_bits, cfg_stop2, cfg_parity_en, cfg_parity_odd,
        input  data_rd, err_clr,
        output data, rx_valid, fifo_level, framing_err, parity_err, overrun_err, break_det, dbg_state
    );

    modport master (
        output rx_in, cfg_divisor, cfg_data_bits, cfg_stop2, cfg_parity_en, cfg_parity_odd,
        output data_rd, err_clr,
        input  data, rx_valid, fifo_level, framing_err, parity_err, overrun_err, break_det, dbg_state
    );
endinterface

// File: rtl/rx_uart_cfg.sv
// Runtime-configurable UART receiver: oversampled majority-vote sampling, 5-8 data bits, 1/2 stop bits,
// break detect, sticky errors and an RX FIFO. Parity support is built only when RX_UART_CFG_PARITY_EN is defined.
module rx_uart_cfg #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    rx_uart_cfg_if.slave bus
);
    localparam int OSW = $clog2(OVERSAMPLE);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;

    localparam logic [OSW-1:0]       SAMP0   = OSW'(OVERSAMPLE/2 - 1);
    localparam logic [OSW-1:0]       SAMP1   = OSW'(OVERSAMPLE/2);
    localparam logic [OSW-1:0]       SAMP2   = OSW'(OVERSAMPLE/2 + 1);
    localparam logic [OSW-1:0]       OS_LAST = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0]       OS_ONE  = OSW'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
    localparam logic [PW-1:0]        PTR_ONE = PW'(1);
    localparam logic [LW-1:0]        LVL_ONE = LW'(1);
    localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_COMMIT, ST_BRKWAIT
    } state_e;

    state_e               state_q, state_d;
    logic                 sync1_q, sync2_q, hist_q;
    logic [DIV_WIDTH-1:0] tcnt_q, tcnt_d, div_q, div_d;
    logic [OSW-1:0]       os_q, os_d;
    logic [1:0]           samp_q, samp_d;
    logic [1:0]           bits_q, bits_d;
    logic                 stop2_q, stop2_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           data_q, data_d;
    logic                 stop_bad_q, stop_bad_d;
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]        level_q, level_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic                 fe_q, fe_d, pe_q, pe_d, ov_q, ov_d, brk_q, brk_d;

    logic start_det, tick, decide, maj;
    logic par_cap, push_req, set_fe, set_pe, set_brk;
    logic parity_act, parity_bad, par_bit;
    logic pop, full, push_ok, set_ov;

    // A start is a falling edge of the synchronised line seen while idle.
    assign start_det = (state_q == ST_IDLE) && hist_q && !sync2_q;
    assign tick      = (tcnt_q == div_q);
    assign decide    = tick && (os_q == SAMP2);
    assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);

    always_comb begin
        tcnt_d  = tcnt_q;
        os_d    = os_q;
        samp_d  = samp_q;
        div_d   = div_q;
        bits_d  = bits_q;
        stop2_d = stop2_q;
        if (start_det) begin
            tcnt_d  = '0;
            os_d    = '0;
            div_d   = bus.cfg_divisor;
            bits_d  = bus.cfg_data_bits;
            stop2_d = bus.cfg_stop2;
        end else if (tick) begin
            tcnt_d = '0;
            os_d   = (os_q == OS_LAST) ? '0 : os_q + OS_ONE;
            if (os_q == SAMP0) samp_d[0] = sync2_q;
            if (os_q == SAMP1) samp_d[1] = sync2_q;
        end else begin
            tcnt_d = tcnt_q + DIV_ONE;
        end
    end

`ifdef RX_UART_CFG_PARITY_EN
    logic par_en_q, par_odd_q, par_bit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (start_det) begin
            par_en_q  <= bus.cfg_parity_en;
            par_odd_q <= bus.cfg_parity_odd;
            par_bit_q <= 1'b0;
        end else if (par_cap) begin
            par_bit_q <= maj;
        end
    end

    assign parity_act = par_en_q;
    assign par_bit    = par_bit_q;
    assign parity_bad = ((^data_q) ^ par_bit_q) != par_odd_q;
`else
    logic unused_parity;
    assign parity_act    = 1'b0;
    assign par_bit       = 1'b0;
    assign parity_bad    = 1'b0;
    assign unused_parity = &{1'b0, bus.cfg_parity_en, bus.cfg_parity_odd, par_cap};
`endif

    // Each bit state decides at its third sample; the free-running tick index keeps bit alignment.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        data_d     = data_q;
        stop_bad_d = stop_bad_q;
        par_cap    = 1'b0;
        push_req   = 1'b0;
        set_fe     = 1'b0;
        set_pe     = 1'b0;
        set_brk    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_det) begin
                    state_d    = ST_START;
                    bit_d      = '0;
                    data_d     = '0;
                    stop_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (decide) state_d = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    data_d[bit_q] = maj;
                    if (bit_q == ({1'b0, bits_q} + 3'd4)) begin
                        state_d = parity_act ? ST_PARITY : ST_STOP1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    par_cap = 1'b1;
                    state_d = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (decide) begin
                    stop_bad_d = stop_bad_q | !maj;
                    state_d    = stop2_q ? ST_STOP2 : ST_COMMIT;
                end
            end
            ST_STOP2: begin
                if (decide) begin
                    stop_bad_d = stop_bad_q | !maj;
                    state_d    = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (stop_bad_q && (data_q == 8'd0) && !par_bit) begin
                    set_brk = 1'b1;
                    state_d = ST_BRKWAIT;
                end else if (stop_bad_q) begin
                    set_fe  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    push_req = 1'b1;
                    set_pe   = parity_act && parity_bad;
                    state_d  = ST_IDLE;
                end
            end
            ST_BRKWAIT: begin
                if (sync2_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head is popped in the same clock.
    assign pop     = bus.data_rd && (level_q != '0);
    assign full    = (level_q == LVL_FULL);
    assign push_ok = push_req && (!full || pop);
    assign set_ov  = push_req && full && !pop;

    always_comb begin
        wr_d    = push_ok ? wr_q + PTR_ONE : wr_q;
        rd_d    = pop ? rd_q + PTR_ONE : rd_q;
        level_d = level_q;
        if (push_ok && !pop)      level_d = level_q + LVL_ONE;
        else if (pop && !push_ok) level_d = level_q - LVL_ONE;
        fe_d  = set_fe  | (fe_q  & !bus.err_clr);
        pe_d  = set_pe  | (pe_q  & !bus.err_clr);
        ov_d  = set_ov  | (ov_q  & !bus.err_clr);
        brk_d = set_brk | (brk_q & !bus.err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            hist_q     <= 1'b1;
            tcnt_q     <= '0;
            os_q       <= '0;
            samp_q     <= '0;
            div_q      <= '0;
            bits_q     <= '0;
            stop2_q    <= 1'b0;
            state_q    <= ST_IDLE;
            bit_q      <= '0;
            data_q     <= '0;
            stop_bad_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            ov_q       <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync1_q    <= bus.rx_in;
            sync2_q    <= sync1_q;
            hist_q     <= sync2_q;
            tcnt_q     <= tcnt_d;
            os_q       <= os_d;
            samp_q     <= samp_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            stop2_q    <= stop2_d;
            state_q    <= state_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            stop_bad_q <= stop_bad_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            ov_q       <= ov_d;
            brk_q      <= brk_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_q;
    end

    assign bus.data        = (level_q == '0) ? 32'hFFFF_FFFF : {24'd0, mem_q[rd_q]};
    assign bus.rx_valid    = (level_q != '0);
    assign bus.fifo_level  = level_q;
    assign bus.framing_err = fe_q;
    assign bus.parity_err  = pe_q;
    assign bus.overrun_err = ov_q;
    assign bus.break_det   = brk_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_rx_uart_cfg.sv
// Self-checking bench for rx_uart_cfg: directed scenarios plus randomized frames checked against
// a frame-level model (expected-byte queue and sticky flag bits).
module tb_rx_uart_cfg;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_WIDTH  = 16;
  localparam int FIFO_DEPTH = 16;
`ifdef RX_UART_CFG_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rx_uart_cfg_if #(.DIV_WIDTH(DIV_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  rx_uart_cfg #(
    .OVERSAMPLE(OVERSAMPLE), .DIV_WIDTH(DIV_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: FIFO contents and sticky flags.
  logic [31:0] exp_q[$];
  bit m_fe, m_pe, m_ov, m_brk;
  int n_tests = 0;
  int n_fail  = 0;

  // Current frame configuration.
  int c_div, c_nb, c_st2, c_pen, c_podd;

  function automatic int bit_clks();
    return (c_div + 1) * OVERSAMPLE;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/data"}, bus.data, (exp_q.size() != 0) ? exp_q[0] : 32'hFFFF_FFFF);
    chk({tag, "/rx_valid"}, {31'd0, bus.rx_valid}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
    chk({tag, "/level"}, 32'(bus.fifo_level), 32'(exp_q.size()));
    chk({tag, "/framing"}, {31'd0, bus.framing_err}, {31'd0, m_fe});
    chk({tag, "/parity"}, {31'd0, bus.parity_err}, {31'd0, m_pe});
    chk({tag, "/overrun"}, {31'd0, bus.overrun_err}, {31'd0, m_ov});
    chk({tag, "/break"}, {31'd0, bus.break_det}, {31'd0, m_brk});
  endtask

  task automatic apply_cfg();
    bus.cfg_divisor    = DIV_WIDTH'(c_div);
    bus.cfg_data_bits  = 2'(c_nb - 5);
    bus.cfg_stop2      = c_st2[0];
    bus.cfg_parity_en  = c_pen[0];
    bus.cfg_parity_odd = c_podd[0];
  endtask

  task automatic set_cfg(input int div, input int nb, input int st2, input int pen, input int podd);
    c_div = div; c_nb = nb; c_st2 = st2; c_pen = pen; c_podd = podd;
    apply_cfg();
  endtask

  task automatic line(input logic v, input int n);
    bus.rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame with the current config; flip_par corrupts the parity bit, bad_stop drives the last stop 0.
  task automatic send_frame(input logic [7:0] d_in, input bit flip_par, input bit bad_stop);
    logic [7:0] d;
    bit fr[$];
    bit par_act, pbit, good_par;
    d        = d_in & 8'((1 << c_nb) - 1);
    par_act  = PAR_BUILD && (c_pen != 0);
    good_par = (c_podd != 0) ? ~(^d) : (^d);
    pbit     = good_par ^ flip_par;
    fr.push_back(1'b0);
    for (int i = 0; i < c_nb; i++) fr.push_back(d[i]);
    if (par_act) fr.push_back(pbit);
    fr.push_back(1'b1);
    if (c_st2 != 0) fr.push_back(1'b1);
    fr[fr.size() - 1] = !bad_stop;
    for (int i = 0; i < fr.size(); i++) begin
      line(fr[i], bit_clks());
      if (i == 0) begin
        // Configuration is latched at the start edge; later changes must not matter.
        bus.cfg_divisor    = DIV_WIDTH'($urandom_range(0, 7));
        bus.cfg_data_bits  = 2'($urandom_range(0, 3));
        bus.cfg_stop2      = 1'($urandom_range(0, 1));
        bus.cfg_parity_en  = 1'($urandom_range(0, 1));
        bus.cfg_parity_odd = 1'($urandom_range(0, 1));
      end
    end
    apply_cfg();
    line(1'b1, bit_clks());
    if (bad_stop) begin
      if (d == 8'd0 && !(par_act && pbit)) m_brk = 1'b1;
      else m_fe = 1'b1;
    end else begin
      if (exp_q.size() == FIFO_DEPTH) m_ov = 1'b1;
      else exp_q.push_back({24'd0, d});
      if (par_act && (((^d) ^ pbit) != c_podd[0])) m_pe = 1'b1;
    end
  endtask

  task automatic pop_one();
    bus.data_rd = 1'b1;
    @(negedge clk);
    bus.data_rd = 1'b0;
    @(negedge clk);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    @(negedge clk);
    m_fe = 0; m_pe = 0; m_ov = 0; m_brk = 0;
  endtask

  task automatic do_reset();
    bus.rx_in = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    m_fe = 0; m_pe = 0; m_ov = 0; m_brk = 0;
    check_all("in_reset");
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] first_byte;
    bus.rx_in = 1'b1; bus.data_rd = 1'b0; bus.err_clr = 1'b0;
    set_cfg(3, 8, 0, 0, 0);
    @(negedge clk);
    do_reset();
    check_all("after_reset");

    // 8N1 at divisor 3
    send_frame(8'hA5, 1'b0, 1'b0);
    chk("a5_data", bus.data, 32'h0000_00A5);
    check_all("a5");
    pop_one();
    chk("a5_pop", bus.data, 32'hFFFF_FFFF);
    pop_one();
    check_all("pop_empty");

    // 5 data bits, 2 stop bits; then a frame with a bad second stop bit
    set_cfg(3, 5, 1, 0, 0);
    send_frame(8'h13, 1'b0, 1'b0);
    chk("x13_data", bus.data, 32'h0000_0013);
    send_frame(8'h0A, 1'b0, 1'b1);
    chk("stop2_framing", {31'd0, bus.framing_err}, 32'd1);
    check_all("stop2");
    clear_err();
    pop_one();
    check_all("stop2_clr");

    // Odd parity with a wrong parity bit: byte still pushed
    set_cfg(3, 8, 0, 1, 1);
    send_frame(8'h01, 1'b1, 1'b0);
    check_all("parity");
    clear_err();
    check_all("parity_clr");
    pop_one();

    // Overrun: fill, then one more
    set_cfg(0, 8, 0, 0, 0);
    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    first_byte = exp_q[0];
    send_frame(8'h77, 1'b0, 1'b0);
    chk("ovr_level", 32'(bus.fifo_level), FIFO_DEPTH);
    chk("ovr_head", bus.data, first_byte);
    check_all("overrun");
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      pop_one();
      check_all("drain");
    end
    clear_err();

    // Short glitch ignored; long low is a break, then a normal frame
    set_cfg(3, 8, 0, 0, 0);
    line(1'b0, bit_clks() * 3 / 10);
    line(1'b1, bit_clks() * 2);
    check_all("glitch");
    line(1'b0, bit_clks() * 12);
    m_brk = 1'b1;
    check_all("break");
    line(1'b1, bit_clks() * 2);
    send_frame(8'h55, 1'b0, 1'b0);
    check_all("after_break");
    clear_err();
    pop_one();

    // Reset in the middle of a data bit with bytes queued
    for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    check_all("pre_reset");
    line(1'b0, bit_clks() * 3);
    do_reset();
    check_all("post_reset");
    send_frame(8'hC3, 1'b0, 1'b0);
    check_all("post_reset_frame");
    pop_one();

    // Randomized frames, configs, reads and clears
    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      set_cfg($urandom_range(0, 2), $urandom_range(5, 8), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 1));
      d = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      send_frame(d, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
      check_all("rand");
      for (int k = $urandom_range(0, 2); k > 0; k--) begin
        pop_one();
        check_all("rand_pop");
      end
      if ($urandom_range(0, 4) == 0) begin
        clear_err();
        check_all("rand_clr");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
